data_sram_bridge: RTL and testbench

- Memory-stage bridge between the mips core's data port and a split-transaction SRAM-like data bus.
- Converts the core's single-cycle mem request into a req/addr_ok/data_ok handshake, generates byte strobes and lane-replicated write data, and returns the read word.
- Asserts a stall to the pipeline until the transaction completes.
- Sits directly downstream of the core, feeding its readdataM/stallM path.

---
 rtl/data_sram_bridge.sv | 159 +++++++++++++++
 tb/tb_data_sram_bridge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Memory-stage bridge: turns the core's single-cycle load/store into a
// req/addr_ok/data_ok SRAM-like bus transaction and stalls the pipeline meanwhile.
module data_sram_bridge #(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wen,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        ext_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        addr_err,
    output logic        done_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned;
    logic [31:0] phys_addr;
    logic [3:0]  wstrb_in;
    logic [31:0] wdata_in;

    // Decode alignment, physical address, strobes and lane-replicated data from the core.
    always_comb begin
        misaligned = 1'b0;
        wstrb_in   = 4'b0000;
        wdata_in   = mem_wdata;
        unique case (mem_size)
            2'b00: begin
                wstrb_in = 4'b0001 << mem_addr[1:0];
                wdata_in = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = mem_addr[0];
                wstrb_in   = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in   = {2{mem_wdata[15:0]}};
            end
            default: begin
                misaligned = (mem_addr[1:0] != 2'b00);
                wstrb_in   = 4'b1111;
            end
        endcase
        if (!mem_wen) begin
            wstrb_in = 4'b0000;
        end
        if (KSEG_MAP && (mem_addr[31:30] == 2'b10)) begin
            phys_addr = {3'b000, mem_addr[28:0]};
        end else begin
            phys_addr = mem_addr;
        end
    end

    assign addr_err = mem_en & misaligned;

    // Next-state logic: capture in IDLE, handshake in REQ/WAIT, hold in DONE under ext_stall.
    always_comb begin
        state_d   = state_q;
        wen_d     = wen_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_en && !misaligned) begin
                    mem_stall = 1'b1;
                    wen_d     = mem_wen;
                    size_d    = mem_size;
                    addr_d    = phys_addr;
                    wstrb_d   = wstrb_in;
                    wdata_d   = wdata_in;
                    state_d   = StReq;
                end
            end
            StReq: begin
                mem_stall = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = StDone;
                        if (!wen_q) begin
                            rdata_d = data_rdata;
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                mem_stall = 1'b1;
                if (data_data_ok) begin
                    state_d = StDone;
                    if (!wen_q) begin
                        rdata_d = data_rdata;
                    end
                end
            end
            StDone: begin
                if (!ext_stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured-request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign done_o     = (state_q == StDone);
    assign mem_rdata  = rdata_q;
    assign data_req   = (state_q == StReq);
    assign data_wr    = wen_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed self-checking bench for data_sram_bridge.
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        ext_stall;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        addr_err;
    logic        done_o;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    int errors = 0;
    int checks = 0;

    data_sram_bridge #(.KSEG_MAP(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .ext_stall    (ext_stall),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .addr_err     (addr_err),
        .done_o       (done_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one access at the current drive phase; addr_ok is raised in cycle ack_at and
    // data_ok in cycle rsp_at (cycle 0 = issue cycle). Returns at the DONE-cycle midpoint.
    task automatic do_txn(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at, input int rsp_at,
                          input logic [31:0] rd, output int stall_cnt, output int req_cnt,
                          output logic [31:0] addr_seen, output logic [31:0] wstrb_seen,
                          output logic [31:0] wdata_seen, output logic [31:0] wr_seen,
                          output logic [31:0] size_seen);
        bit done_seen;
        done_seen  = 1'b0;
        stall_cnt  = 0;
        req_cnt    = 0;
        addr_seen  = 32'hx;
        wstrb_seen = 32'hx;
        wdata_seen = 32'hx;
        wr_seen    = 32'hx;
        size_seen  = 32'hx;
        mem_wen    = wen;
        mem_size   = size;
        mem_addr   = addr;
        mem_wdata  = wdata;
        data_rdata = rd;
        for (int k = 0; k < 30; k++) begin
            mem_en       = (k == 0);
            data_addr_ok = (k == ack_at);
            data_data_ok = (k == rsp_at);
            @(negedge clk);
            if (mem_stall) stall_cnt++;
            if (data_req) begin
                req_cnt++;
                addr_seen  = data_addr;
                wstrb_seen = {28'h0, data_wstrb};
                wdata_seen = data_wdata;
                wr_seen    = {31'h0, data_wr};
                size_seen  = {30'h0, data_size};
            end
            if (done_o) begin
                done_seen = 1'b1;
                break;
            end
            cyc();
        end
        check("txn_completes", {31'h0, done_seen}, 32'h1);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    int          st, rq;
    logic [31:0] a_s, s_s, w_s, wr_s, sz_s;

    initial begin
        rst          = 1'b0;
        mem_en       = 1'b0;
        mem_wen      = 1'b0;
        mem_size     = 2'b00;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        ext_stall    = 1'b0;
        data_addr_ok = 1'b0;
        data_rdata   = 32'h0;
        data_data_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_req", {31'h0, data_req}, 32'h0);
        check("rst_stall", {31'h0, mem_stall}, 32'h0);
        cyc();

        // 1: word load through kseg, split handshake
        do_txn(1'b0, 2'b10, 32'h8000_0010, 32'h0, 1, 3, 32'hDEAD_BEEF,
               st, rq, a_s, s_s, w_s, wr_s, sz_s);
        check("t1_addr", a_s, 32'h0000_0010);
        check("t1_wstrb", s_s, 32'h0);
        check("t1_wr", wr_s, 32'h0);
        check("t1_size", sz_s, 32'h2);
        check("t1_req_cycles", rq, 1);
        check("t1_stall_cycles", st, 4);
        check("t1_rdata", mem_rdata, 32'hDEAD_BEEF);
        check("t1_done_stall", {31'h0, mem_stall}, 32'h0);
        cyc();
        @(negedge clk);
        check("t1_idle_done", {31'h0, done_o}, 32'h0);
        cyc();

        // 2: byte store to lane 3
        do_txn(1'b1, 2'b00, 32'h0000_0003, 32'h0000_12A5, 1, 2, 32'h5555_5555,
               st, rq, a_s, s_s, w_s, wr_s, sz_s);
        check("t2_addr", a_s, 32'h0000_0003);
        check("t2_wstrb", s_s, 32'h8);
        check("t2_wdata", w_s, 32'hA5A5_A5A5);
        check("t2_wr", wr_s, 32'h1);
        check("t2_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
        cyc();
        cyc();

        // 2b: half store to upper half, addr_ok delayed one cycle
        do_txn(1'b1, 2'b01, 32'h0000_0006, 32'h9999_BEEF, 2, 2, 32'h0,
               st, rq, a_s, s_s, w_s, wr_s, sz_s);
        check("t2b_wstrb", s_s, 32'hC);
        check("t2b_wdata", w_s, 32'hBEEF_BEEF);
        check("t2b_size", sz_s, 32'h1);
        check("t2b_addr_held", a_s, 32'h0000_0006);
        check("t2b_req_cycles", rq, 2);
        check("t2b_stall_cycles", st, 3);
        cyc();
        cyc();

        // 3: half load, addr_ok and data_ok together
        do_txn(1'b0, 2'b01, 32'h0000_0002, 32'h0, 1, 1, 32'h1234_5678,
               st, rq, a_s, s_s, w_s, wr_s, sz_s);
        check("t3_wstrb", s_s, 32'h0);
        check("t3_req_cycles", rq, 1);
        check("t3_stall_cycles", st, 2);
        check("t3_rdata", mem_rdata, 32'h1234_5678);
        cyc();
        cyc();

        // 4: misaligned word and half loads
        mem_en   = 1'b1;
        mem_wen  = 1'b0;
        mem_size = 2'b10;
        mem_addr = 32'h0000_0001;
        @(negedge clk);
        check("t4_addr_err", {31'h0, addr_err}, 32'h1);
        check("t4_stall", {31'h0, mem_stall}, 32'h0);
        check("t4_req", {31'h0, data_req}, 32'h0);
        cyc();
        mem_size = 2'b01;
        mem_addr = 32'h0000_0003;
        @(negedge clk);
        check("t4_half_err", {31'h0, addr_err}, 32'h1);
        check("t4_req_after", {31'h0, data_req}, 32'h0);
        cyc();
        mem_en = 1'b0;
        @(negedge clk);
        check("t4_err_clear", {31'h0, addr_err}, 32'h0);
        check("t4_req_never", {31'h0, data_req}, 32'h0);
        cyc();

        // 5: DONE held by ext_stall, inputs ignored meanwhile
        ext_stall = 1'b1;
        do_txn(1'b0, 2'b10, 32'hA000_0020, 32'h0, 1, 1, 32'hCAFE_F00D,
               st, rq, a_s, s_s, w_s, wr_s, sz_s);
        check("t5_addr", a_s, 32'h0000_0020);
        check("t5_rdata_d1", mem_rdata, 32'hCAFE_F00D);
        cyc();
        mem_en     = 1'b1;
        mem_addr   = 32'h0000_0040;
        data_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check("t5_done_d2", {31'h0, done_o}, 32'h1);
        check("t5_rdata_d2", mem_rdata, 32'hCAFE_F00D);
        check("t5_req_d2", {31'h0, data_req}, 32'h0);
        check("t5_stall_d2", {31'h0, mem_stall}, 32'h0);
        cyc();
        mem_en    = 1'b0;
        ext_stall = 1'b0;
        @(negedge clk);
        check("t5_done_d3", {31'h0, done_o}, 32'h1);
        check("t5_rdata_d3", mem_rdata, 32'hCAFE_F00D);
        cyc();
        @(negedge clk);
        check("t5_idle_done", {31'h0, done_o}, 32'h0);
        check("t5_idle_req", {31'h0, data_req}, 32'h0);
        check("t5_idle_stall", {31'h0, mem_stall}, 32'h0);
        cyc();

        // 6: reset in WAIT, stray data_ok afterwards
        mem_en   = 1'b1;
        mem_wen  = 1'b0;
        mem_size = 2'b10;
        mem_addr = 32'h0000_0100;
        cyc();
        mem_en       = 1'b0;
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        @(negedge clk);
        check("t6_in_wait", {31'h0, mem_stall}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_stall", {31'h0, mem_stall}, 32'h0);
        check("t6_rst_req", {31'h0, data_req}, 32'h0);
        check("t6_rst_rdata", mem_rdata, 32'h0);
        check("t6_rst_done", {31'h0, done_o}, 32'h0);
        cyc();
        rst          = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_FFFF;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("t6_stray_rdata", mem_rdata, 32'h0);
        check("t6_stray_done", {31'h0, done_o}, 32'h0);
        check("t6_stray_stall", {31'h0, mem_stall}, 32'h0);
        data_data_ok = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
